// File: rtl/ps2_pkg.sv
// Shared types for the PS/2 event dispatcher: event record, state encoding
// and the routing rule that picks a consumer port from an event's flags.
package ps2_pkg;

  localparam int CODE_W = 5;
  localparam int FLAG_W = 3;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic [FLAG_W-1:0] flags;
  } ps2_event_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRES_A = 2'd1,
    PRES_B = 2'd2
  } ps2_state_e;

  // Plain data keys (no class flags) go to port A, everything else to port B.
  function automatic ps2_state_e routeEvent(input logic [FLAG_W-1:0] flags);
    return (flags == '0) ? PRES_A : PRES_B;
  endfunction

endpackage

// File: rtl/ps2_event_ram.sv
// Event storage behind the head stage: synchronous write, asynchronous read.
// Holds DEPTH-1 entries; the controller owns all pointers.
module ps2_event_ram
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  ps2_event_t    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output ps2_event_t    rdata_o
);

  ps2_event_t mem [DEPTH-1];

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/ps2_event_dispatcher.sv
// Buffers PS/2 key events and hands them out in order to a data port (A)
// or a command port (B), counting every event lost to overflow.
module ps2_event_dispatcher
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ev_valid,
  input  logic [CODE_W-1:0] ev_code,
  input  logic [FLAG_W-1:0] ev_flags,
  input  logic              flush,
  output logic              a_valid,
  input  logic              a_ready,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [CODE_W-1:0] out_code,
  output logic [FLAG_W-1:0] out_flags,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic [7:0]        drop_cnt
);

  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 2);

  ps2_state_e    state_q;
  ps2_event_t    head_q;
  logic          aValid_q, bValid_q;
  logic [AW-1:0] wrPtr_q, rdPtr_q, bufCnt_q;
  logic [AW:0]   count_q;
  logic          overflow_q;
  logic [7:0]    dropCnt_q;

  ps2_event_t evIn, ramRdata, head_d;
  logic pop, accept, drop, bufEmpty, loadFromBuf, loadFromIn, loadHead, bufWrite;

  // The buffer wraps at DEPTH-1 entries, so the pointer compare is explicit.
  function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + AW'(1);
  endfunction

  assign evIn        = '{code: ev_code, flags: ev_flags};
  assign pop         = (state_q == PRES_A && a_ready) || (state_q == PRES_B && b_ready);
  assign accept      = ev_valid && (count_q != FULL);
  assign drop        = ev_valid && (count_q == FULL);
  assign bufEmpty    = (bufCnt_q == '0);
  assign loadFromBuf = pop && !bufEmpty;
  assign loadFromIn  = accept && ((state_q == IDLE) || (pop && bufEmpty));
  assign loadHead    = loadFromBuf || loadFromIn;
  assign head_d      = loadFromBuf ? ramRdata : evIn;
  assign bufWrite    = !flush && accept && !loadFromIn;

  ps2_event_ram #(.DEPTH(DEPTH), .AW(AW)) uRam (
    .clk     (clk),
    .we_i    (bufWrite),
    .waddr_i (wrPtr_q),
    .wdata_i (evIn),
    .raddr_i (rdPtr_q),
    .rdata_o (ramRdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      head_q     <= '0;
      aValid_q   <= 1'b0;
      bValid_q   <= 1'b0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      bufCnt_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      dropCnt_q  <= '0;
    end else if (flush) begin
      state_q    <= IDLE;
      aValid_q   <= 1'b0;
      bValid_q   <= 1'b0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      bufCnt_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      dropCnt_q  <= '0;
    end else begin
      if (loadHead) begin
        head_q   <= head_d;
        state_q  <= routeEvent(head_d.flags);
        aValid_q <= (routeEvent(head_d.flags) == PRES_A);
        bValid_q <= (routeEvent(head_d.flags) == PRES_B);
      end else if (pop) begin
        state_q  <= IDLE;
        aValid_q <= 1'b0;
        bValid_q <= 1'b0;
      end

      if (loadFromBuf) rdPtr_q <= nextPtr(rdPtr_q);
      if (bufWrite)    wrPtr_q <= nextPtr(wrPtr_q);

      case ({bufWrite, loadFromBuf})
        2'b10:   bufCnt_q <= bufCnt_q + AW'(1);
        2'b01:   bufCnt_q <= bufCnt_q - AW'(1);
        default: bufCnt_q <= bufCnt_q;
      endcase

      case ({accept, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase

      // A pop on the same edge never frees room for an event seen while full.
      if (drop) begin
        overflow_q <= 1'b1;
        if (dropCnt_q != 8'hFF) dropCnt_q <= dropCnt_q + 8'd1;
      end
    end
  end

  assign a_valid   = aValid_q;
  assign b_valid   = bValid_q;
  assign out_code  = head_q.code;
  assign out_flags = head_q.flags;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = dropCnt_q;

endmodule

// File: tb/tb_ps2_event_dispatcher.sv
// Self-checking bench for ps2_event_dispatcher: a scoreboard of expected
// deliveries plus directed checks of counters, routing, flush and reset.
module tb_ps2_event_dispatcher;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ev_valid;
  logic [4:0] ev_code;
  logic [2:0] ev_flags;
  logic       flush;
  logic       a_valid, a_ready, b_valid, b_ready;
  logic [4:0] out_code;
  logic [2:0] out_flags;
  logic [3:0] count;
  logic       overflow;
  logic [7:0] drop_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int delivered   = 0;

  // Each entry: {port (0=A,1=B), code, flags}
  logic [8:0] expQ [$];

  ps2_event_dispatcher #(.DEPTH(8), .AW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ev_valid  (ev_valid),
    .ev_code   (ev_code),
    .ev_flags  (ev_flags),
    .flush     (flush),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .out_code  (out_code),
    .out_flags (out_flags),
    .count     (count),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one event for exactly one clock; push it if it is expected to be delivered.
  task automatic applyStimulus(input logic [4:0] code, input logic [2:0] flags, input bit expectDelivery);
    ev_valid = 1'b1;
    ev_code  = code;
    ev_flags = flags;
    if (expectDelivery) expQ.push_back({(flags != 3'b000), code, flags});
    @(posedge clk);
    #1;
    ev_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (count != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drainCount", count, 0);
  endtask

  // Scoreboard side: a handshake seen at the negedge completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_valid && b_valid) checkOutput("bothValid", 1, 0);
      if ((a_valid && a_ready) || (b_valid && b_ready)) begin
        delivered++;
        if (expQ.size() == 0) begin
          checkOutput("spuriousEvent", {b_valid, out_code, out_flags}, 0);
        end else begin
          logic [8:0] exp;
          exp = expQ.pop_front();
          checkOutput("deliveredEvent", {b_valid, out_code, out_flags}, exp);
        end
      end
    end
  end

  initial begin
    int d0;
    rst_n    = 1'b0;
    ev_valid = 1'b0;
    ev_code  = '0;
    ev_flags = '0;
    flush    = 1'b0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    checkOutput("rstAValid", a_valid, 0);
    checkOutput("rstBValid", b_valid, 0);
    checkOutput("rstCode", out_code, 0);
    checkOutput("rstCount", count, 0);
    checkOutput("rstOverflow", overflow, 0);
    checkOutput("rstDrop", drop_cnt, 0);

    // Single event, one-cycle latency
    applyStimulus(5'h0A, 3'b000, 1);
    checkOutput("t1AValid", a_valid, 1);
    checkOutput("t1BValid", b_valid, 0);
    checkOutput("t1Code", out_code, 5'h0A);
    checkOutput("t1Count", count, 1);
    a_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t1AValidDone", a_valid, 0);
    checkOutput("t1CountDone", count, 0);

    // Back-to-back A/B/A with both readies high
    b_ready = 1'b1;
    applyStimulus(5'h01, 3'b000, 1);
    checkOutput("t2First", {a_valid, b_valid, out_code}, {2'b10, 5'h01});
    applyStimulus(5'h02, 3'b010, 1);
    checkOutput("t2Second", {a_valid, b_valid, out_code}, {2'b01, 5'h02});
    applyStimulus(5'h03, 3'b000, 1);
    checkOutput("t2Third", {a_valid, b_valid, out_code}, {2'b10, 5'h03});
    waitDrain();

    // Stalled A: 9 events, the last is dropped
    a_ready = 1'b0;
    for (int i = 0; i < 9; i++) applyStimulus(5'h10 + 5'(i), 3'b000, i < 8);
    checkOutput("t3Count", count, 8);
    checkOutput("t3Overflow", overflow, 1);
    checkOutput("t3Drop", drop_cnt, 1);
    checkOutput("t3HeadCode", out_code, 5'h10);
    d0 = delivered;
    a_ready = 1'b1;
    waitDrain();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t3Delivered", delivered - d0, 8);

    // Full block: event and handshake on the same edge, event still dropped
    a_ready = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(5'h20 + 5'(i), 3'b000, 1);
    a_ready = 1'b1;
    applyStimulus(5'h1F, 3'b000, 0);
    checkOutput("t4Count", count, 7);
    checkOutput("t4Drop", drop_cnt, 2);
    waitDrain();

    // B head holds while only the ignored A ready is high
    b_ready = 1'b0;
    applyStimulus(5'h05, 3'b100, 1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("routeHold", {a_valid, b_valid, out_code, out_flags}, {2'b01, 5'h05, 3'b100});
    checkOutput("routeCount", count, 1);
    b_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("routeDone", b_valid, 0);

    // Asynchronous reset while presenting on B with 4 stored events
    b_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(5'h11 + 5'(i), 3'b001, 1);
    checkOutput("t6PreCount", count, 4);
    checkOutput("t6PreBValid", b_valid, 1);
    #3 rst_n = 1'b0;
    #1;
    expQ.delete();
    checkOutput("t6RstOutputs", {a_valid, b_valid, out_code, out_flags, count, overflow, drop_cnt},
                0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    a_ready = 1'b1;
    b_ready = 1'b1;
    applyStimulus(5'h0C, 3'b000, 1);
    checkOutput("t6Fresh", {a_valid, b_valid, out_code}, {2'b10, 5'h0C});
    waitDrain();

    // Saturating drop counter, then flush with a coincident event
    a_ready = 1'b0;
    b_ready = 1'b0;
    for (int i = 0; i < 300; i++) applyStimulus(5'(i), 3'b000, i < 8);
    checkOutput("t5Count", count, 8);
    checkOutput("t5Overflow", overflow, 1);
    checkOutput("t5DropSat", drop_cnt, 255);
    flush    = 1'b1;
    ev_valid = 1'b1;
    ev_code  = 5'h1E;
    ev_flags = 3'b000;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    ev_valid = 1'b0;
    expQ.delete();
    checkOutput("t5FlushCount", count, 0);
    checkOutput("t5FlushOverflow", overflow, 0);
    checkOutput("t5FlushDrop", drop_cnt, 0);
    checkOutput("t5FlushValid", {a_valid, b_valid}, 0);
    a_ready = 1'b1;
    b_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t5PostFlush", {a_valid, b_valid, count}, 0);

    checkOutput("scoreboardEmpty", expQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
